// File: rtl/cla_pkg.sv
// Shared helpers for the decomposed CLA: monomial-vector sizing and group layout.
package cla_pkg;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  // Total count of non-linear carry monomials for an nbit adder.
  function automatic int nnl(input int nbit);
    return (1 << (nbit + 2)) - nbit - 4;
  endfunction

  // Bit offset of carry group k inside the monomial vector.
  function automatic int grp_off(input int k);
    return (1 << (k + 1)) - k - 3;
  endfunction

  // Number of monomials in carry group k (group 0 is just c_in).
  function automatic int grp_len(input int k);
    return (1 << (k + 1)) - 1;
  endfunction

endpackage

// File: rtl/nonlinear_part_seq_group_gen.sv
// Builds carry group k from group k-1: {ak&bk, ak&T(k-1), bk&T(k-1)}.
module nl_group_gen
  import cla_pkg::*;
#(
  parameter int NBIT = 4
) (
  input  logic                            ak,
  input  logic                            bk,
  input  logic [(1 << NBIT) - 2:0]        prev,
  input  logic [$clog2(NBIT + 1) - 1:0]   k,
  output logic [(1 << (NBIT + 1)) - 2:0]  grp
);

  localparam int PW = (1 << NBIT) - 1;
  localparam int GW = (1 << (NBIT + 1)) - 1;

  logic [PW-1:0] a_term;
  logic [PW-1:0] b_term;
  int            lp;

  // prev arrives masked to its true length, so the b terms land directly after the a terms.
  always_comb begin
    lp     = grp_len(int'(k) - 1);
    a_term = {PW{ak}} & prev;
    b_term = {PW{bk}} & prev;
    grp    = GW'(ak & bk) | (GW'(a_term) << 1) | (GW'(b_term) << (lp + 1));
  end

endmodule

// File: rtl/nonlinear_part_seq.sv
// Iterative generator of the non-linear carry monomials, one carry group per cycle.
module nonlinear_part_seq
  import cla_pkg::*;
#(
  parameter  int NBIT = 4,
  localparam int NNL  = nnl(NBIT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            c_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NNL-1:0]  n,
  output logic [NBIT-1:0] a_o,
  output logic [NBIT-1:0] b_o,
  output logic            c_o
);

  localparam int PW = (1 << NBIT) - 1;
  localparam int GW = (1 << (NBIT + 1)) - 1;
  localparam int KW = $clog2(NBIT + 1);
  localparam logic [NNL-1:0] NNL_ONES = '1;
  localparam logic [PW-1:0]  PW_ONES  = '1;

  state_t         state;
  state_t         state_next;
  logic [KW-1:0]  k;
  logic           accept;
  logic [PW-1:0]  prev;
  logic [GW-1:0]  grp;
  logic [NNL-1:0] gmask;
  logic [NNL-1:0] n_next;
  int             kk;
  int             cur_off;
  int             cur_len;
  int             prv_off;
  int             prv_len;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = GEN;
        end
      end
      GEN: begin
        if (k == KW'(NBIT)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          accept     = in_valid;
          state_next = in_valid ? GEN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Group k-1 is read back out of n; group 0 lives only in c_o.
  always_comb begin
    kk      = int'(k);
    cur_off = grp_off(kk);
    cur_len = grp_len(kk);
    prv_off = (kk > 1) ? grp_off(kk - 1) : 0;
    prv_len = (kk > 1) ? grp_len(kk - 1) : 0;
    prev    = '0;
    if (kk == 1) prev[0] = c_o;
    else if (kk > 1) prev = PW'(n >> prv_off) & (PW_ONES >> (PW - prv_len));
    gmask  = (NNL_ONES >> (NNL - cur_len)) << cur_off;
    n_next = (n & ~gmask) | ((NNL'(grp) << cur_off) & gmask);
  end

  nl_group_gen #(.NBIT(NBIT)) u_group_gen (
    .ak   (a_o[k - 1'b1]),
    .bk   (b_o[k - 1'b1]),
    .prev (prev),
    .k    (k),
    .grp  (grp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      n     <= '0;
      a_o   <= '0;
      b_o   <= '0;
      c_o   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_o <= a;
        b_o <= b;
        c_o <= c_in;
        n   <= '0;
        k   <= KW'(1);
      end else if (state == GEN) begin
        n <= n_next;
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nonlinear_part_seq.sv
// Randomized bench: monomial vector vs. a list-based model, and linear-stage sum vs. a+b+c_in.
module tb_nonlinear_part_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] n;
  logic [3:0]  a_o;
  logic [3:0]  b_o;
  logic        c_o;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [55:0] last_n;
  logic [4:0]  last_sum;

  nonlinear_part_seq #(.NBIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n         (n),
    .a_o       (a_o),
    .b_o       (b_o),
    .c_o       (c_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Groups grown as plain bit lists; concatenating them in order gives n.
  function automatic logic [55:0] model_n(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
    bit          t[$];
    bit          nt[$];
    logic [55:0] r;
    int          pos;
    r   = '0;
    pos = 0;
    t.push_back(tc);
    for (int k = 0; k < 4; k++) begin
      nt.delete();
      nt.push_back(ta[k[1:0]] & tb_v[k[1:0]]);
      foreach (t[j]) nt.push_back(ta[k[1:0]] & t[j]);
      foreach (t[j]) nt.push_back(tb_v[k[1:0]] & t[j]);
      foreach (nt[i]) begin
        if (nt[i]) r = r | (56'd1 << pos);
        pos++;
      end
      t = nt;
    end
    return r;
  endfunction

  // Pure-XOR linear stage: carry into bit k is the parity of group k.
  function automatic logic [4:0] lin(input logic [55:0] nv, input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
    logic [4:0] r;
    logic       cy;
    int         off;
    int         len;
    r   = '0;
    cy  = tc;
    off = 0;
    len = 3;
    for (int k = 0; k < 4; k++) begin
      r[k[2:0]] = ta[k[1:0]] ^ tb_v[k[1:0]] ^ cy;
      cy  = ^((nv >> off) & ((56'd1 << len) - 56'd1));
      off = off + len;
      len = 2 * len + 1;
    end
    r[4] = cy;
    return r;
  endfunction

  task automatic wait_result(input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd5);
  endtask

  task automatic run_txn(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc, input int stall);
    logic [55:0] exp_n;
    exp_n    = model_n(ta, tb_v, tc);
    a        = ta;
    b        = tb_v;
    c_in     = tc;
    in_valid = 1'b1;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", {62'd0, out_valid, in_ready}, 64'd0);
    wait_result("txn");
    check("n", 64'(n), 64'(exp_n));
    check("ops", {55'd0, a_o, b_o, c_o}, {55'd0, ta, tb_v, tc});
    last_n   = n;
    last_sum = lin(n, a_o, b_o, c_o);
    check("sum", 64'(last_sum), 64'(5'(ta) + 5'(tb_v) + 5'(tc)));
    repeat (stall) begin
      @(posedge clk); #1;
      check("hold", {6'd0, out_valid, in_ready, n}, {6'd0, 1'b1, 1'b0, exp_n});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("released", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int          idx[512];
    int          tmp;
    int          r;
    logic [8:0]  v;
    logic [55:0] exp_n;
    bit          seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    #1;
    check("reset_outs", {7'd0, out_valid, n}, 64'd0);
    check("reset_ops", {55'd0, a_o, b_o, c_o}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed cases
    run_txn(4'h0, 4'h0, 1'b1, 0);
    check("t1_n", 64'(last_n), 64'd0);
    check("t1_sum", 64'(last_sum), 64'h01);
    run_txn(4'hF, 4'hF, 1'b1, 1);
    check("t2_n", 64'(last_n), 64'h00FF_FFFF_FFFF_FFFF);
    check("t2_sum", 64'(last_sum), 64'h1F);
    run_txn(4'hF, 4'h1, 1'b0, 0);
    check("t3_n_low", 64'(last_n[2:0]), 64'b001);
    check("t3_sum", 64'(last_sum), 64'h10);

    // Back-pressure then same-cycle handoff
    exp_n    = model_n(4'h9, 4'h6, 1'b1);
    a        = 4'h9;
    b        = 4'h6;
    c_in     = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp_first");
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_hold", {6'd0, out_valid, in_ready, n}, {6'd0, 1'b1, 1'b0, exp_n});
    end
    a         = 4'h3;
    b         = 4'h5;
    c_in      = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("bp_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_gen", {62'd0, out_valid, in_ready}, 64'd0);
    check("bp_ops", {55'd0, a_o, b_o, c_o}, {55'd0, 4'h3, 4'h5, 1'b0});
    wait_result("bp_second");
    check("bp_n", 64'(n), 64'(model_n(4'h3, 4'h5, 1'b0)));
    check("bp_sum", 64'(lin(n, a_o, b_o, c_o)), 64'h08);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of generation
    a        = 4'hF;
    b        = 4'hF;
    c_in     = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_n", {7'd0, out_valid, n}, 64'd0);
    check("midrst_ops", {55'd0, a_o, b_o, c_o}, 64'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    run_txn(4'h7, 4'h9, 1'b1, 0);

    // All operand combinations in shuffled order
    for (int i = 0; i < 512; i++) idx[i] = i;
    for (int i = 511; i > 0; i--) begin
      r      = int'($urandom_range(i, 0));
      tmp    = idx[i];
      idx[i] = idx[r];
      idx[r] = tmp;
    end
    for (int i = 0; i < 512; i++) begin
      v = 9'(idx[i]);
      run_txn(v[3:0], v[7:4], v[8], int'($urandom_range(2, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
